control_sequencer: RTL and testbench

Hard-wired Moore control unit that sequences the CPU datapath through fetch and execute T-states. It decodes opcode ir[31:27] and drives every datapath strobe through one packed control vector. It sits beside the datapath, with ir fed from the IR register output and con from the CON flip-flop. It supports run/halt control, a configurable memory wait and an instruction counter.

---
 rtl/control_sequencer_if.sv | 25 ++
 rtl/control_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the CPU datapath.
// The sequencer side (master) consumes run/ir/con and drives the strobe vector
// plus status; the datapath side (slave) is the mirror image.
interface control_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [31:0]      ir;
    logic             con;
    logic [31:0]      ctl;
    logic [3:0]       t_state;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, ir, con,
        output ctl, t_state, halted, illegal, instr_count
    );

    modport slave (
        output run, ir, con,
        input  ctl, t_state, halted, illegal, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// Hard-wired Moore control unit: walks the datapath through fetch (T0..T2)
// and opcode-specific execute states (T3..T7), with run/halt control,
// a configurable memory hold and a retired-instruction counter.
module control_sequencer #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clock,
    input  logic              clear,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV,
        C_MFHI, C_MFLO, C_IN, C_OUT, C_NOP, C_HALT, C_ILL
    } op_class_t;

    // Last value of the wait counter in a held memory state.
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    // Strobe positions inside ctl.
    localparam int B_PCO    = 0;
    localparam int B_PCI    = 1;
    localparam int B_INCPC  = 2;
    localparam int B_IRI    = 3;
    localparam int B_MARI   = 4;
    localparam int B_MDRI   = 5;
    localparam int B_MDRO   = 6;
    localparam int B_MEMR   = 7;
    localparam int B_MEMW   = 8;
    localparam int B_RYI    = 9;
    localparam int B_RZHI   = 10;
    localparam int B_RZLI   = 11;
    localparam int B_RZHO   = 12;
    localparam int B_RZLO   = 13;
    localparam int B_HII    = 14;
    localparam int B_HIO    = 15;
    localparam int B_LOI    = 16;
    localparam int B_LOO    = 17;
    localparam int B_GRA    = 18;
    localparam int B_GRB    = 19;
    localparam int B_GRC    = 20;
    localparam int B_RIN    = 21;
    localparam int B_ROUT   = 22;
    localparam int B_BAOUT  = 23;
    localparam int B_CSIGNO = 24;
    localparam int B_IPO    = 25;
    localparam int B_OPI    = 26;

    function automatic op_class_t class_of(input logic [4:0] op);
        op_class_t c;
        case (op) inside
            5'd0:           c = C_LD;
            5'd1:           c = C_LDI;
            5'd2:           c = C_ST;
            [5'd3:5'd11]:   c = C_ALU;
            [5'd12:5'd14]:  c = C_IMM;
            5'd15, 5'd16:   c = C_MULDIV;
            5'd20:          c = C_MFHI;
            5'd21:          c = C_MFLO;
            5'd22:          c = C_IN;
            5'd23:          c = C_OUT;
            5'd26:          c = C_NOP;
            5'd27:          c = C_HALT;
            default:        c = C_ILL;
        endcase
        return c;
    endfunction

    // Strobes asserted while sitting in state s for an instruction of class c.
    function automatic logic [31:0] ctl_of(input state_t s, input op_class_t c);
        logic [31:0] v;
        v = '0;
        case (s)
            S_T0: begin v[B_PCO] = 1'b1; v[B_MARI] = 1'b1; v[B_INCPC] = 1'b1; v[B_PCI] = 1'b1; end
            S_T1: begin v[B_MEMR] = 1'b1; v[B_MDRI] = 1'b1; end
            S_T2: begin v[B_MDRO] = 1'b1; v[B_IRI] = 1'b1; end
            S_T3: begin
                case (c)
                    C_ALU, C_IMM:      begin v[B_GRB] = 1'b1; v[B_ROUT] = 1'b1; v[B_RYI] = 1'b1; end
                    C_LDI, C_LD, C_ST: begin v[B_GRB] = 1'b1; v[B_BAOUT] = 1'b1; v[B_RYI] = 1'b1; end
                    C_MULDIV:          begin v[B_GRA] = 1'b1; v[B_ROUT] = 1'b1; v[B_RYI] = 1'b1; end
                    C_MFHI:            begin v[B_HIO] = 1'b1; v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
                    C_MFLO:            begin v[B_LOO] = 1'b1; v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
                    C_IN:              begin v[B_IPO] = 1'b1; v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
                    C_OUT:             begin v[B_GRA] = 1'b1; v[B_ROUT] = 1'b1; v[B_OPI] = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (c)
                    C_ALU:                    begin v[B_GRC] = 1'b1; v[B_ROUT] = 1'b1; v[B_RZLI] = 1'b1; end
                    C_IMM, C_LDI, C_LD, C_ST: begin v[B_CSIGNO] = 1'b1; v[B_RZLI] = 1'b1; end
                    C_MULDIV: begin
                        v[B_GRB] = 1'b1; v[B_ROUT] = 1'b1; v[B_RZHI] = 1'b1; v[B_RZLI] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (c)
                    C_ALU, C_IMM, C_LDI: begin v[B_RZLO] = 1'b1; v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
                    C_LD, C_ST:          begin v[B_RZLO] = 1'b1; v[B_MARI] = 1'b1; end
                    C_MULDIV:            begin v[B_RZLO] = 1'b1; v[B_LOI] = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (c)
                    C_LD:     begin v[B_MEMR] = 1'b1; v[B_MDRI] = 1'b1; end
                    C_ST:     begin v[B_GRA] = 1'b1; v[B_ROUT] = 1'b1; v[B_MDRI] = 1'b1; end
                    C_MULDIV: begin v[B_RZHO] = 1'b1; v[B_HII] = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (c)
                    C_LD:    begin v[B_MDRO] = 1'b1; v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
                    C_ST:    v[B_MEMW] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return v;
    endfunction

    function automatic state_t boundary(input logic run);
        return run ? S_T0 : S_IDLE;
    endfunction

    function automatic state_t next_of(input state_t s, input logic run,
                                       input op_class_t c, input logic [3:0] w);
        state_t n;
        case (s)
            S_IDLE: n = run ? S_T0 : S_IDLE;
            S_T0:   n = S_T1;
            S_T1:   n = (w == WAIT_LAST) ? S_T2 : S_T1;
            S_T2:   n = (c == C_HALT) ? S_HALT : S_T3;
            S_T3:   n = (c inside {C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV}) ? S_T4 : boundary(run);
            S_T4:   n = S_T5;
            S_T5:   n = (c inside {C_LD, C_ST, C_MULDIV}) ? S_T6 : boundary(run);
            S_T6: begin
                case (c)
                    C_LD:    n = (w == WAIT_LAST) ? S_T7 : S_T6;
                    C_ST:    n = S_T7;
                    default: n = boundary(run);
                endcase
            end
            S_T7: begin
                if (c == C_ST) n = (w == WAIT_LAST) ? boundary(run) : S_T7;
                else           n = boundary(run);
            end
            S_HALT: n = S_HALT;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    // States that touch memory and are stretched by the wait counter.
    function automatic logic is_held(input state_t s, input op_class_t c);
        return (s == S_T1) || (s == S_T6 && c == C_LD) || (s == S_T7 && c == C_ST);
    endfunction

    state_t           state;
    state_t           state_nxt;
    op_class_t        cls;
    logic [4:0]       op_q;
    logic [3:0]       wait_cnt;
    logic [31:0]      ctl_r;
    logic             illegal_r;
    logic [CNT_W-1:0] count;

    // IR becomes meaningful at the end of T2, so the decision leaving T2 looks at
    // ir directly; afterwards the opcode captured at that moment is used.
    assign cls       = class_of((state == S_T2) ? bus.ir[31:27] : op_q);
    assign state_nxt = next_of(state, bus.run, cls, wait_cnt);

    // Sequencer state, wait counter, instruction counter and registered strobes.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= S_IDLE;
            op_q      <= '0;
            wait_cnt  <= '0;
            ctl_r     <= '0;
            illegal_r <= 1'b0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            ctl_r     <= ctl_of(state_nxt, cls);
            illegal_r <= (state_nxt == S_T3) && (cls == C_ILL);
            if (state == S_T2) begin
                op_q  <= bus.ir[31:27];
                count <= count + CNT_W'(1);
            end
            if (is_held(state, cls) && state_nxt == state) wait_cnt <= wait_cnt + 4'd1;
            else                                           wait_cnt <= '0;
        end
    end

    assign bus.ctl         = ctl_r;
    assign bus.t_state     = state;
    assign bus.halted      = (state == S_HALT);
    assign bus.illegal     = illegal_r;
    assign bus.instr_count = count;

    // con is reserved for branch support and the operand fields are decoded by
    // the datapath, so neither affects sequencing here.
    logic unused_inputs;
    assign unused_inputs = ^{bus.con, bus.ir[26:0]};

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (memory hold 0 and 2) driven from
// directed and random opcode streams, compared cycle by cycle against a
// table-built list of expected T-states and strobes.
module tb_control_sequencer;

    localparam int CNT_W = 16;
    localparam int MW0   = 0;
    localparam int MW1   = 2;

    localparam logic [31:0] PCO    = 32'd1 << 0;
    localparam logic [31:0] PCI    = 32'd1 << 1;
    localparam logic [31:0] INCPC  = 32'd1 << 2;
    localparam logic [31:0] IRI    = 32'd1 << 3;
    localparam logic [31:0] MARI   = 32'd1 << 4;
    localparam logic [31:0] MDRI   = 32'd1 << 5;
    localparam logic [31:0] MDRO   = 32'd1 << 6;
    localparam logic [31:0] MEMR   = 32'd1 << 7;
    localparam logic [31:0] MEMW   = 32'd1 << 8;
    localparam logic [31:0] RYI    = 32'd1 << 9;
    localparam logic [31:0] RZHI   = 32'd1 << 10;
    localparam logic [31:0] RZLI   = 32'd1 << 11;
    localparam logic [31:0] RZHO   = 32'd1 << 12;
    localparam logic [31:0] RZLO   = 32'd1 << 13;
    localparam logic [31:0] HII    = 32'd1 << 14;
    localparam logic [31:0] HIO    = 32'd1 << 15;
    localparam logic [31:0] LOI    = 32'd1 << 16;
    localparam logic [31:0] LOO    = 32'd1 << 17;
    localparam logic [31:0] GRA    = 32'd1 << 18;
    localparam logic [31:0] GRB    = 32'd1 << 19;
    localparam logic [31:0] GRC    = 32'd1 << 20;
    localparam logic [31:0] RIN    = 32'd1 << 21;
    localparam logic [31:0] ROUT   = 32'd1 << 22;
    localparam logic [31:0] BAOUT  = 32'd1 << 23;
    localparam logic [31:0] CSIGNO = 32'd1 << 24;
    localparam logic [31:0] IPO    = 32'd1 << 25;
    localparam logic [31:0] OPI    = 32'd1 << 26;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir_d;
    logic        con_d;
    logic        run_d [2];

    always #5 clock = ~clock;

    control_sequencer_if #(.CNT_W(CNT_W)) bus0 ();
    control_sequencer_if #(.CNT_W(CNT_W)) bus1 ();

    assign bus0.run = run_d[0];
    assign bus0.ir  = ir_d;
    assign bus0.con = con_d;
    assign bus1.run = run_d[1];
    assign bus1.ir  = ir_d;
    assign bus1.con = con_d;

    control_sequencer #(.MEM_WAIT(MW0), .CNT_W(CNT_W)) dut0 (
        .clock(clock), .clear(clear), .bus(bus0.master)
    );
    control_sequencer #(.MEM_WAIT(MW1), .CNT_W(CNT_W)) dut1 (
        .clock(clock), .clear(clear), .bus(bus1.master)
    );

    logic [31:0]      o_ctl [2];
    logic [3:0]       o_ts  [2];
    logic             o_hlt [2];
    logic             o_ill [2];
    logic [CNT_W-1:0] o_cnt [2];

    assign o_ctl[0] = bus0.ctl;         assign o_ctl[1] = bus1.ctl;
    assign o_ts[0]  = bus0.t_state;     assign o_ts[1]  = bus1.t_state;
    assign o_hlt[0] = bus0.halted;      assign o_hlt[1] = bus1.halted;
    assign o_ill[0] = bus0.illegal;     assign o_ill[1] = bus1.illegal;
    assign o_cnt[0] = bus0.instr_count; assign o_cnt[1] = bus1.instr_count;

    typedef struct {
        logic [3:0]  ts;
        logic [31:0] ctl;
        logic        ill;
    } step_t;

    step_t            exp_q [$];
    int               mw_of [2] = '{MW0, MW1};
    logic [CNT_W-1:0] cnt_exp [2];
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input int ts, input logic [31:0] c, input int reps, input logic ill);
        step_t s;
        s.ts  = 4'(ts);
        s.ctl = c;
        s.ill = ill;
        for (int r = 0; r < reps; r++) exp_q.push_back(s);
    endtask

    // Expected cycle-by-cycle listing of one instruction, straight from the opcode table.
    task automatic build(input logic [4:0] op, input int mw);
        exp_q.delete();
        push(1, PCO | MARI | INCPC | PCI, 1, 1'b0);
        push(2, MEMR | MDRI, mw + 1, 1'b0);
        push(3, MDRO | IRI, 1, 1'b0);
        if (op == 5'd27) return;
        if (op >= 5'd3 && op <= 5'd11) begin
            push(4, GRB | ROUT | RYI, 1, 1'b0);
            push(5, GRC | ROUT | RZLI, 1, 1'b0);
            push(6, RZLO | GRA | RIN, 1, 1'b0);
        end else if (op >= 5'd12 && op <= 5'd14) begin
            push(4, GRB | ROUT | RYI, 1, 1'b0);
            push(5, CSIGNO | RZLI, 1, 1'b0);
            push(6, RZLO | GRA | RIN, 1, 1'b0);
        end else if (op == 5'd1) begin
            push(4, GRB | BAOUT | RYI, 1, 1'b0);
            push(5, CSIGNO | RZLI, 1, 1'b0);
            push(6, RZLO | GRA | RIN, 1, 1'b0);
        end else if (op == 5'd0) begin
            push(4, GRB | BAOUT | RYI, 1, 1'b0);
            push(5, CSIGNO | RZLI, 1, 1'b0);
            push(6, RZLO | MARI, 1, 1'b0);
            push(7, MEMR | MDRI, mw + 1, 1'b0);
            push(8, MDRO | GRA | RIN, 1, 1'b0);
        end else if (op == 5'd2) begin
            push(4, GRB | BAOUT | RYI, 1, 1'b0);
            push(5, CSIGNO | RZLI, 1, 1'b0);
            push(6, RZLO | MARI, 1, 1'b0);
            push(7, GRA | ROUT | MDRI, 1, 1'b0);
            push(8, MEMW, mw + 1, 1'b0);
        end else if (op == 5'd15 || op == 5'd16) begin
            push(4, GRA | ROUT | RYI, 1, 1'b0);
            push(5, GRB | ROUT | RZHI | RZLI, 1, 1'b0);
            push(6, RZLO | LOI, 1, 1'b0);
            push(7, RZHO | HII, 1, 1'b0);
        end else if (op == 5'd20) push(4, HIO | GRA | RIN, 1, 1'b0);
        else if (op == 5'd21)     push(4, LOO | GRA | RIN, 1, 1'b0);
        else if (op == 5'd22)     push(4, IPO | GRA | RIN, 1, 1'b0);
        else if (op == 5'd23)     push(4, GRA | ROUT | OPI, 1, 1'b0);
        else if (op == 5'd26)     push(4, 32'd0, 1, 1'b0);
        else                      push(4, 32'd0, 1, 1'b1);
    endtask

    // Runs one instruction on instance k from IDLE or an instruction boundary.
    // stop_ts != 0 returns right after the first cycle spent in that t_state.
    task automatic exec(input int k, input logic [31:0] instr, input logic run_after, input int stop_ts);
        logic [4:0] op;
        step_t      s;
        int         last;
        op = instr[31:27];
        build(op, mw_of[k]);
        last     = exp_q.size() - 1;
        ir_d     = instr;
        run_d[k] = 1'b1;
        for (int i = 0; i <= last; i++) begin
            s = exp_q[i];
            @(posedge clock); #1;
            check($sformatf("d%0d op%0d c%0d t_state", k, op, i), 64'(o_ts[k]), 64'(s.ts));
            check($sformatf("d%0d op%0d c%0d ctl", k, op, i), 64'(o_ctl[k]), 64'(s.ctl));
            check($sformatf("d%0d op%0d c%0d illegal", k, op, i), 64'(o_ill[k]), 64'(s.ill));
            check($sformatf("d%0d op%0d c%0d halted", k, op, i), 64'(o_hlt[k]), 64'(0));
            if (s.ts == 4'd3) cnt_exp[k] = cnt_exp[k] + 1'b1;
            if (stop_ts != 0 && int'(s.ts) == stop_ts) return;
            con_d = 1'($urandom);
            if (i == last && op != 5'd27) run_d[k] = run_after;
            else                          run_d[k] = 1'($urandom_range(0, 1));
        end
        if (op == 5'd27) begin
            for (int c = 0; c < 100; c++) begin
                @(posedge clock); #1;
                check($sformatf("d%0d halt c%0d t_state", k, c), 64'(o_ts[k]), 64'(15));
                check($sformatf("d%0d halt c%0d halted", k, c), 64'(o_hlt[k]), 64'(1));
                check($sformatf("d%0d halt c%0d ctl", k, c), 64'(o_ctl[k]), 64'(0));
                run_d[k] = 1'($urandom_range(0, 1));
            end
            check($sformatf("d%0d halt instr_count", k), 64'(o_cnt[k]), 64'(cnt_exp[k]));
            return;
        end
        check($sformatf("d%0d op%0d instr_count", k, op), 64'(o_cnt[k]), 64'(cnt_exp[k]));
        check($sformatf("d%0d other idle", k), 64'(o_ts[1-k]), 64'(0));
        if (!run_after) begin
            @(posedge clock); #1;
            check($sformatf("d%0d op%0d idle t_state", k, op), 64'(o_ts[k]), 64'(0));
            check($sformatf("d%0d op%0d idle ctl", k, op), 64'(o_ctl[k]), 64'(0));
        end
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s d%0d t_state", tag, k), 64'(o_ts[k]), 64'(0));
            check($sformatf("%s d%0d ctl", tag, k), 64'(o_ctl[k]), 64'(0));
            check($sformatf("%s d%0d halted", tag, k), 64'(o_hlt[k]), 64'(0));
            check($sformatf("%s d%0d illegal", tag, k), 64'(o_ill[k]), 64'(0));
            check($sformatf("%s d%0d instr_count", tag, k), 64'(o_cnt[k]), 64'(0));
        end
    endtask

    task automatic random_stream(input int k, input int n);
        logic [4:0]  op;
        logic [31:0] instr;
        for (int j = 0; j < n; j++) begin
            op = 5'($urandom_range(0, 31));
            while (op == 5'd27) op = 5'($urandom_range(0, 31));
            instr = {op, 27'($urandom)};
            exec(k, instr, (j != n - 1), 0);
        end
    endtask

    logic [31:0] directed [14] = '{
        32'h1800_0000, 32'h1000_0000, 32'h9000_0000, 32'h0000_0000,
        32'h7800_0000, 32'hD000_0000, 32'hA000_0000, 32'hA800_0000,
        32'hB000_0000, 32'hB800_0000, 32'h6000_0000, 32'h0800_0000,
        32'h8000_0000, 32'hE000_0000
    };

    initial begin
        clear      = 1'b0;
        run_d[0]   = 1'b0;
        run_d[1]   = 1'b0;
        ir_d       = 32'd0;
        con_d      = 1'b0;
        cnt_exp[0] = '0;
        cnt_exp[1] = '0;

        repeat (2) @(posedge clock);
        #1;
        check_reset("reset");
        @(negedge clock);
        clear = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("idle hold d0", 64'(o_ts[0]), 64'(0));
        check("idle hold d1", 64'(o_ts[1]), 64'(0));

        foreach (directed[i]) exec(0, directed[i], 1'b1, 0);
        random_stream(0, 20);

        exec(1, 32'h0000_0000, 1'b1, 0);
        exec(1, 32'h1000_0000, 1'b1, 0);
        exec(1, 32'h1800_0000, 1'b1, 0);
        exec(1, 32'h9000_0000, 1'b1, 0);
        random_stream(1, 20);

        exec(0, 32'hD800_0000, 1'b1, 0);
        clear = 1'b0;
        #1;
        check_reset("halt clear");
        cnt_exp[0] = '0;
        cnt_exp[1] = '0;
        run_d[0]   = 1'b0;
        run_d[1]   = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;

        exec(1, 32'h7800_0000, 1'b1, 5);
        clear    = 1'b0;
        run_d[1] = 1'b0;
        #1;
        check("mul clear ctl", 64'(o_ctl[1]), 64'(0));
        check("mul clear t_state", 64'(o_ts[1]), 64'(0));
        check("mul clear instr_count", 64'(o_cnt[1]), 64'(0));
        cnt_exp[1] = '0;
        @(negedge clock);
        clear = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check_reset("post clear idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
